// File: rtl/alu_uart_sequencer.sv
// Control FSM for the UART-to-ALU calculator: collects an A/B/opcode frame,
// waits out the ALU latency and hands one result byte to the UART transmitter.
module alu_uart_sequencer #(
  parameter int              DBIT           = 8,
  parameter int              ALU_LAT        = 1,
  parameter int              TIMEOUT_CYCLES = 50000000,
  parameter logic [DBIT-1:0] ERR_BYTE       = 8'hEE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] op_a,
  output logic [DBIT-1:0] op_b,
  output logic [5:0]      op_code,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic [7:0]      err_count
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX} state_t;

  localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAT_LAST = 4'(ALU_LAT - 1);
  localparam logic [5:0]      OP_ADD   = 6'h20;

  state_t            state, state_next;
  logic [DBIT-1:0]   op_a_next, op_b_next, tx_data_next;
  logic [5:0]        op_code_next;
  logic [7:0]        err_next;
  logic [TO_W-1:0]   to_cnt, to_cnt_next;
  logic [3:0]        lat_cnt, lat_cnt_next;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  function automatic logic opcode_valid(input logic [5:0] op);
    case (op)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  assign tx_start = (state == SEND);
  assign busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_next   = state;
    op_a_next    = op_a;
    op_b_next    = op_b;
    op_code_next = op_code;
    tx_data_next = tx_data;
    to_cnt_next  = '0;
    lat_cnt_next = '0;
    err_inc      = 2'd0;

    case (state)
      GET_A: begin
        if (rx_done_tick) begin
          op_a_next  = rx_data;
          state_next = GET_B;
        end
      end
      GET_B: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_done_tick) begin
          op_b_next  = rx_data;
          state_next = GET_OP;
        end else if (to_cnt == TO_LAST) begin
          state_next = GET_A;
          err_inc    = 2'd1;
        end else begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end
      GET_OP: begin
        if (rx_done_tick) begin
          op_code_next = rx_data[5:0];
          state_next   = EXEC;
        end else if (to_cnt == TO_LAST) begin
          state_next = GET_A;
          err_inc    = 2'd1;
        end else begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end
      EXEC: begin
        if (lat_cnt == LAT_LAST) begin
          state_next = SEND;
          if (opcode_valid(op_code)) begin
            tx_data_next = alu_result;
          end else begin
            tx_data_next = ERR_BYTE;
            err_inc      = 2'd1;
          end
        end else begin
          lat_cnt_next = lat_cnt + 4'd1;
        end
      end
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_next = GET_A;
      default: state_next = GET_A;
    endcase

    // Bytes arriving while busy are dropped; this can coincide with an
    // invalid-opcode error in the last EXEC cycle, hence a 2-bit increment.
    if (rx_done_tick && busy) err_inc = err_inc + 2'd1;

    err_sum  = 9'(err_count) + 9'(err_inc);
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= GET_A;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= OP_ADD;
      tx_data   <= '0;
      err_count <= '0;
      to_cnt    <= '0;
      lat_cnt   <= '0;
    end else begin
      state     <= state_next;
      op_a      <= op_a_next;
      op_b      <= op_b_next;
      op_code   <= op_code_next;
      tx_data   <= tx_data_next;
      err_count <= err_next;
      to_cnt    <= to_cnt_next;
      lat_cnt   <= lat_cnt_next;
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a behavioural ALU and
// hand-computed expected bytes.
module tb_alu_uart_sequencer;

  localparam int ALU_LAT = 1;
  localparam int TO      = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_done_tick = 1'b0;
  logic [7:0] op_a, op_b, tx_data, err_count;
  logic [5:0] op_code;
  logic       tx_start, busy;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;

  alu_uart_sequencer #(
    .DBIT(8), .ALU_LAT(ALU_LAT), .TIMEOUT_CYCLES(TO), .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .alu_result(alu_result), .tx_done_tick(tx_done_tick), .op_a(op_a),
    .op_b(op_b), .op_code(op_code), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // External ALU stand-in, combinational so it settles within ALU_LAT = 1.
  always_comb begin
    case (op_code)
      6'h20:   alu_result = op_a + op_b;
      6'h22:   alu_result = op_a - op_b;
      6'h24:   alu_result = op_a & op_b;
      6'h25:   alu_result = op_a | op_b;
      6'h26:   alu_result = op_a ^ op_b;
      6'h27:   alu_result = ~(op_a | op_b);
      6'h03:   alu_result = 8'($signed(op_a) >>> op_b[2:0]);
      6'h02:   alu_result = op_a >> op_b[2:0];
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (tx_start) tx_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Called right after the opcode byte; follows the result through to GET_A.
  task automatic complete_tx(input logic [7:0] exp_data, input logic [7:0] exp_err,
                             input bit inject);
    int n = 0;
    while (!tx_start && n < 20) begin
      step(1);
      n++;
    end
    check("tx_latency", n, ALU_LAT);
    check("tx_data", tx_data, exp_data);
    step(1);
    check("tx_single_pulse", tx_start, 0);
    check("busy_wait_tx", busy, 1);
    if (inject) send_byte(8'h77);
    check("tx_data_held", tx_data, exp_data);
    tx_done_tick = 1'b1;
    step(1);
    tx_done_tick = 1'b0;
    check("idle_after_done", busy, 0);
    check("err_count", err_count, exp_err);
  endtask

  initial begin
    int p;
    step(2);
    check("rst_op_a", op_a, 8'h00);
    check("rst_op_b", op_b, 8'h00);
    check("rst_op_code", op_code, 6'h20);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 8'h00);
    reset = 1'b1;
    step(2);

    // Basic ADD frame.
    send_frame(8'h05, 8'h03, 8'h20);
    check("cap_op_a", op_a, 8'h05);
    check("cap_op_b", op_b, 8'h03);
    check("cap_op_code", op_code, 6'h20);
    check("busy_exec", busy, 1);
    check("no_early_start", tx_start, 0);
    complete_tx(8'h08, 8'h00, 1'b0);

    // Invalid opcode still drives op_code but sends the error byte.
    send_frame(8'hF0, 8'h0F, 8'h3F);
    check("bad_op_code", op_code, 6'h3F);
    complete_tx(8'hEE, 8'h01, 1'b0);

    // Timeout in GET_B: one cycle short does nothing, the full count aborts.
    p = tx_pulses;
    send_byte(8'h11);
    step(TO - 1);
    check("to_not_yet", err_count, 8'h01);
    step(1);
    check("to_err", err_count, 8'h02);
    check("to_no_tx", tx_pulses, p);
    check("to_op_a_held", op_a, 8'h11);
    send_frame(8'h01, 8'h02, 8'h20);
    complete_tx(8'h03, 8'h02, 1'b0);

    // Byte arriving on the very cycle the timeout expires is accepted.
    send_byte(8'h22);
    step(TO - 1);
    send_byte(8'h33);
    check("byte_wins_err", err_count, 8'h02);
    send_byte(8'h24);
    complete_tx(8'h22, 8'h02, 1'b0);

    // Stray byte during WAIT_TX is dropped and counted.
    send_frame(8'h0A, 8'h05, 8'h22);
    complete_tx(8'h05, 8'h03, 1'b1);
    send_frame(8'h09, 8'h04, 8'h26);
    check("realign_op_a", op_a, 8'h09);
    complete_tx(8'h0D, 8'h03, 1'b0);
    send_frame(8'hF0, 8'h02, 8'h03);
    complete_tx(8'hFC, 8'h03, 1'b0);
    send_frame(8'h0F, 8'hF0, 8'h27);
    complete_tx(8'h00, 8'h03, 1'b0);

    // Asynchronous reset while waiting for the transmitter.
    send_frame(8'h01, 8'h01, 8'h20);
    step(2);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("arst_op_a", op_a, 8'h00);
    check("arst_op_code", op_code, 6'h20);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_err", err_count, 8'h00);
    step(1);
    reset = 1'b1;
    p = tx_pulses;
    tx_done_tick = 1'b1;
    step(1);
    tx_done_tick = 1'b0;
    step(5);
    check("post_rst_no_tx", tx_pulses, p);

    // Asynchronous reset while waiting for the opcode.
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b0;
    #1;
    check("arst2_op_a", op_a, 8'h00);
    check("arst2_op_b", op_b, 8'h00);
    step(1);
    reset = 1'b1;
    step(3);
    check("post_rst2_no_tx", tx_pulses, p);
    send_frame(8'h02, 8'h03, 8'h25);
    complete_tx(8'h03, 8'h00, 1'b0);

    // Error counter saturation.
    for (int i = 1; i <= 260; i++) begin
      send_frame(8'h01, 8'h01, 8'h3F);
      complete_tx(8'hEE, (i > 255) ? 8'hFF : 8'(i), 1'b0);
    end
    check("sat_final", err_count, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Control FSM that sequences the UART-to-ALU calculator datapath.
- Collects a 3-byte command frame from the UART receiver (operand A, operand B, opcode) and drives the ALU operand and opcode inputs.
- Waits for the registered ALU result, then hands the result byte to the UART transmitter using the tx_start / tx_done_tick handshake.
- Adds an inter-byte timeout, opcode validation and a saturating error counter. It replaces the ad-hoc split between the receive-side and transmit-side glue.

Parameters:
- DBIT, 8, data and operand width in bits (matches the UART word).
- ALU_LAT, 1, number of clk cycles from stable operands to a valid ALU result (range 1..15).
- TIMEOUT_CYCLES, 50000000, clk cycles allowed between bytes of one frame before the frame is aborted.
- ERR_BYTE, 8'hEE, byte transmitted in place of a result when the opcode is invalid.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx_done_tick  in  1  one-cycle pulse: a received byte is valid on rx_data.
- rx_data  in  DBIT  received byte.
- alu_result  in  DBIT  ALU output.
- tx_done_tick  in  1  one-cycle pulse: the transmitter has finished the current byte.
- op_a  out  DBIT  ALU operand A (registered).
- op_b  out  DBIT  ALU operand B (registered).
- op_code  out  6  ALU opcode (registered).
- tx_start  out  1  one-cycle pulse: start transmitting tx_data.
- tx_data  out  DBIT  byte to transmit (registered, held stable until tx_done_tick).
- busy  out  1  high in the EXEC, SEND and WAIT_TX states.
- err_count  out  8  saturating count of aborted or errored frames.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = GET_A.
  - op_a, op_b, tx_data = 0; op_code = 6'h20 (ADD).
  - tx_start = 0, busy = 0, err_count = 0.
  - Timeout and latency counters cleared.
  - Reset asserted mid-frame or mid-transmission aborts everything immediately; no tx_start is issued after reset deasserts until a new full frame is received.
- States:
  - GET_A: on rx_done_tick, op_a <= rx_data, go to GET_B.
  - GET_B: on rx_done_tick, op_b <= rx_data, go to GET_OP.
  - GET_OP: on rx_done_tick, op_code <= rx_data[5:0], go to EXEC.
  - EXEC: wait ALU_LAT cycles, counted from the first cycle in EXEC. On the final cycle:
    - tx_data <= alu_result if the opcode is valid, otherwise ERR_BYTE;
    - go to SEND.
  - SEND: tx_start = 1 for exactly one cycle, go to WAIT_TX.
  - WAIT_TX: on tx_done_tick, go to GET_A.
- Valid opcodes: 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h03 SRA, 6'h02 SRL. Any other value is invalid.
  - An invalid opcode still drives op_code, but ERR_BYTE is transmitted and err_count increments (saturating at 255).
- Latency: tx_start pulses exactly ALU_LAT+1 cycles after the cycle in which the opcode rx_done_tick is sampled.
- Operand hold: op_a, op_b and op_code keep their values from capture until overwritten by the next frame's corresponding byte. They are never cleared on timeout.
- Timeout:
  - Applies in GET_B and GET_OP only. The counter runs from entry into the state and is cleared on each accepted byte.
  - On reaching TIMEOUT_CYCLES: go to GET_A, err_count increments (saturating), nothing is transmitted.
  - GET_A has no timeout; idle is unbounded.
- Simultaneous events:
  - rx_done_tick in the same cycle the timeout expires: the byte wins; it is accepted and no error is counted.
  - rx_done_tick while busy (EXEC, SEND or WAIT_TX): the byte is dropped, err_count increments (saturating), and the state is unaffected.
  - tx_done_tick outside WAIT_TX: ignored.
- err_count saturates at 8'hFF and never wraps.
- tx_start is never high outside SEND and never high for two consecutive cycles.

Test Plan:
- Reset, then frame 8'h05, 8'h03, 8'h20, with ALU model result = 8'h08 and ALU_LAT = 1 → op_a = 05, op_b = 03, op_code = 20. tx_start pulses exactly 2 cycles after the opcode tick with tx_data = 08. Return to GET_A after tx_done_tick; err_count = 0.
- Frame 8'hF0, 8'h0F, 8'h3F (invalid opcode) → tx_data = 8'hEE, one tx_start pulse, err_count = 1.
- TIMEOUT_CYCLES = 100; send 8'h11, then silence for 100 cycles → state returns to GET_A, no tx_start, err_count increments. The next frame 01, 02, 20 yields tx_data = 03.
- Extra rx_done_tick injected during WAIT_TX → byte dropped, err_count +1, current transmission completes normally, next frame decodes correctly (no byte misalignment).
- Assert reset during WAIT_TX and during GET_OP → all outputs return to reset values asynchronously. No tx_start after release until a full new frame arrives.
- Force 260 invalid-opcode frames → err_count stops at 8'hFF.
